// File: rtl/riscv_pkg.sv
// Shared RV32 decode constants and the ID/EX control bundle.
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       branch;
    logic       jump;
    logic [1:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/reg_file.sv
// 2R1W register file, x0 hardwired to zero, WB write-through bypass on reads.
module reg_file #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [4:0]      raddr1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  logic [NREG-1:0][XLEN-1:0] regs;
  logic                      wr_en;

  assign wr_en = we && (waddr != 5'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        regs        <= '0;
    else if (wr_en) regs[waddr] <= wdata;
  end

  // Bypass lets an instruction in ID see the value WB is committing this cycle.
  always_comb begin
    if (raddr1 == 5'd0)                   rdata1 = '0;
    else if (wr_en && (waddr == raddr1))  rdata1 = wdata;
    else                                  rdata1 = regs[raddr1];
    if (raddr2 == 5'd0)                   rdata2 = '0;
    else if (wr_en && (waddr == raddr2))  rdata2 = wdata;
    else                                  rdata2 = regs[raddr2];
  end

endmodule

// File: rtl/id_stage_hazard.sv
// ID stage: decode, immediates, register file, load-use stall and ID/EX register.
module id_stage_hazard
  import riscv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     Instruc_IFID,
  input  logic [XLEN-1:0] PC_IFID,
  input  logic            PCSrc_EX,
  input  logic            RegWrite_WB,
  input  logic [4:0]      Rd_WB,
  input  logic [XLEN-1:0] WriteData_WB,
  output logic            PCWrite,
  output logic            Write_IFID,
  output logic            Flush_IFID,
  output logic [XLEN-1:0] IDEX_PC,
  output logic [XLEN-1:0] IDEX_RD1,
  output logic [XLEN-1:0] IDEX_RD2,
  output logic [XLEN-1:0] IDEX_Imm,
  output logic [4:0]      IDEX_Rs1,
  output logic [4:0]      IDEX_Rs2,
  output logic [4:0]      IDEX_Rd,
  output logic            IDEX_RegWrite,
  output logic            IDEX_MemRead,
  output logic            IDEX_MemWrite,
  output logic            IDEX_MemtoReg,
  output logic            IDEX_ALUSrc,
  output logic            IDEX_Branch,
  output logic            IDEX_Jump,
  output logic [1:0]      IDEX_ALUOp,
  output logic [3:0]      IDEX_Funct
);

  logic [6:0]      opcode;
  logic [4:0]      rd_f, rs1_f, rs2_f, rs1_sel;
  logic [3:0]      funct;
  ctrl_t           ctrl;
  logic [XLEN-1:0] imm, rd1, rd2;
  logic            use_rs1, use_rs2, stall, kill;

  assign opcode = Instruc_IFID[6:0];
  assign rd_f   = Instruc_IFID[11:7];
  assign rs1_f  = Instruc_IFID[19:15];
  assign rs2_f  = Instruc_IFID[24:20];
  assign funct  = {Instruc_IFID[30], Instruc_IFID[14:12]};

  always_comb begin
    ctrl    = '0;
    imm     = '0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    rs1_sel = rs1_f;
    unique case (opcode)
      OP_R: begin
        ctrl.reg_write = 1'b1; ctrl.alu_op = ALUOP_R;
        use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      OP_I: begin
        ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.alu_op = ALUOP_I;
        imm = XLEN'($signed(Instruc_IFID[31:20]));
        use_rs1 = 1'b1;
      end
      OP_LOAD: begin
        ctrl.reg_write = 1'b1; ctrl.mem_read = 1'b1; ctrl.mem_to_reg = 1'b1;
        ctrl.alu_src = 1'b1; ctrl.alu_op = ALUOP_ADD;
        imm = XLEN'($signed(Instruc_IFID[31:20]));
        use_rs1 = 1'b1;
      end
      OP_STORE: begin
        ctrl.mem_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.alu_op = ALUOP_ADD;
        imm = XLEN'($signed({Instruc_IFID[31:25], Instruc_IFID[11:7]}));
        use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      OP_BRANCH: begin
        ctrl.branch = 1'b1; ctrl.alu_op = ALUOP_BR;
        imm = XLEN'($signed({Instruc_IFID[31], Instruc_IFID[7], Instruc_IFID[30:25],
                             Instruc_IFID[11:8], 1'b0}));
        use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      OP_JAL: begin
        ctrl.reg_write = 1'b1; ctrl.jump = 1'b1; ctrl.alu_op = ALUOP_ADD;
        imm = XLEN'($signed({Instruc_IFID[31], Instruc_IFID[19:12], Instruc_IFID[20],
                             Instruc_IFID[30:21], 1'b0}));
      end
      OP_JALR: begin
        ctrl.reg_write = 1'b1; ctrl.jump = 1'b1; ctrl.alu_src = 1'b1;
        ctrl.alu_op = ALUOP_ADD;
        imm = XLEN'($signed(Instruc_IFID[31:20]));
        use_rs1 = 1'b1;
      end
      OP_LUI: begin
        // rs1 forced to x0 so the EX adder computes 0 + imm.
        ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.alu_op = ALUOP_ADD;
        imm = XLEN'($signed({Instruc_IFID[31:12], 12'b0}));
        rs1_sel = 5'd0;
      end
      OP_AUIPC: begin
        ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.alu_op = ALUOP_ADD;
        imm = XLEN'($signed({Instruc_IFID[31:12], 12'b0}));
      end
      default: ;
    endcase
  end

  reg_file #(.XLEN(XLEN), .NREG(NREG)) u_rf (
    .clk    (clk),
    .rst    (rst),
    .we     (RegWrite_WB),
    .waddr  (Rd_WB),
    .wdata  (WriteData_WB),
    .raddr1 (rs1_sel),
    .raddr2 (rs2_f),
    .rdata1 (rd1),
    .rdata2 (rd2)
  );

  assign stall = IDEX_MemRead && (IDEX_Rd != 5'd0) &&
                 ((use_rs1 && (IDEX_Rd == rs1_f)) || (use_rs2 && (IDEX_Rd == rs2_f)));

  // A taken branch overrides the stall: IF must load the target regardless.
  assign PCWrite    = !stall || PCSrc_EX;
  assign Write_IFID = !stall || PCSrc_EX;
  assign Flush_IFID = PCSrc_EX;
  assign kill       = stall || PCSrc_EX;

  ctrl_t idex_ctrl;

  always_ff @(posedge clk or posedge rst) begin
    if (rst || kill) begin
      if (rst || kill) begin
        idex_ctrl  <= '0;
        IDEX_PC    <= '0;
        IDEX_RD1   <= '0;
        IDEX_RD2   <= '0;
        IDEX_Imm   <= '0;
        IDEX_Rs1   <= '0;
        IDEX_Rs2   <= '0;
        IDEX_Rd    <= '0;
        IDEX_Funct <= '0;
      end
    end else begin
      idex_ctrl  <= ctrl;
      IDEX_PC    <= PC_IFID;
      IDEX_RD1   <= rd1;
      IDEX_RD2   <= rd2;
      IDEX_Imm   <= imm;
      IDEX_Rs1   <= rs1_sel;
      IDEX_Rs2   <= rs2_f;
      IDEX_Rd    <= rd_f;
      IDEX_Funct <= funct;
    end
  end

  assign IDEX_RegWrite = idex_ctrl.reg_write;
  assign IDEX_MemRead  = idex_ctrl.mem_read;
  assign IDEX_MemWrite = idex_ctrl.mem_write;
  assign IDEX_MemtoReg = idex_ctrl.mem_to_reg;
  assign IDEX_ALUSrc   = idex_ctrl.alu_src;
  assign IDEX_Branch   = idex_ctrl.branch;
  assign IDEX_Jump     = idex_ctrl.jump;
  assign IDEX_ALUOp    = idex_ctrl.alu_op;

endmodule

// File: tb/tb_id_stage_hazard.sv
// Scoreboard bench for id_stage_hazard: stimulus pushes expected ID/EX and stall
// outputs; monitors pop and compare at negedge (stall controls) and after posedge (ID/EX).
module tb_id_stage_hazard;

  typedef struct packed {
    logic [31:0] pc, rd1, rd2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [6:0]  ctrl;   // RegWrite MemRead MemWrite MemtoReg ALUSrc Branch Jump
    logic [1:0]  aluop;
    logic [3:0]  funct;
  } ex_t;
  typedef struct packed { logic pcw, wif, fl; } hz_t;

  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] Instruc_IFID = 32'h13, PC_IFID = '0, WriteData_WB = '0;
  logic        PCSrc_EX = 1'b0, RegWrite_WB = 1'b0;
  logic [4:0]  Rd_WB = '0;
  logic        PCWrite, Write_IFID, Flush_IFID;
  logic [31:0] IDEX_PC, IDEX_RD1, IDEX_RD2, IDEX_Imm;
  logic [4:0]  IDEX_Rs1, IDEX_Rs2, IDEX_Rd;
  logic        IDEX_RegWrite, IDEX_MemRead, IDEX_MemWrite, IDEX_MemtoReg;
  logic        IDEX_ALUSrc, IDEX_Branch, IDEX_Jump;
  logic [1:0]  IDEX_ALUOp;
  logic [3:0]  IDEX_Funct;

  id_stage_hazard dut (
    .clk(clk), .rst(rst), .Instruc_IFID(Instruc_IFID), .PC_IFID(PC_IFID),
    .PCSrc_EX(PCSrc_EX), .RegWrite_WB(RegWrite_WB), .Rd_WB(Rd_WB),
    .WriteData_WB(WriteData_WB), .PCWrite(PCWrite), .Write_IFID(Write_IFID),
    .Flush_IFID(Flush_IFID), .IDEX_PC(IDEX_PC), .IDEX_RD1(IDEX_RD1),
    .IDEX_RD2(IDEX_RD2), .IDEX_Imm(IDEX_Imm), .IDEX_Rs1(IDEX_Rs1),
    .IDEX_Rs2(IDEX_Rs2), .IDEX_Rd(IDEX_Rd), .IDEX_RegWrite(IDEX_RegWrite),
    .IDEX_MemRead(IDEX_MemRead), .IDEX_MemWrite(IDEX_MemWrite),
    .IDEX_MemtoReg(IDEX_MemtoReg), .IDEX_ALUSrc(IDEX_ALUSrc),
    .IDEX_Branch(IDEX_Branch), .IDEX_Jump(IDEX_Jump), .IDEX_ALUOp(IDEX_ALUOp),
    .IDEX_Funct(IDEX_Funct)
  );

  always #5 clk = ~clk;

  ex_t act_ex;
  hz_t act_hz;
  assign act_ex = {IDEX_PC, IDEX_RD1, IDEX_RD2, IDEX_Imm, IDEX_Rs1, IDEX_Rs2, IDEX_Rd,
                   IDEX_RegWrite, IDEX_MemRead, IDEX_MemWrite, IDEX_MemtoReg,
                   IDEX_ALUSrc, IDEX_Branch, IDEX_Jump, IDEX_ALUOp, IDEX_Funct};
  assign act_hz = {PCWrite, Write_IFID, Flush_IFID};

  int    checks = 0, failures = 0;
  ex_t   idex_q[$];
  hz_t   hz_q[$];
  string ex_nm_q[$], hz_nm_q[$];
  ex_t   mon_e;
  hz_t   mon_h;
  string mon_en, mon_hn;

  localparam ex_t BUB = '0;

  function automatic ex_t mk(input logic [31:0] pc, rd1, rd2, imm,
                             input logic [4:0] rs1, rs2, rd, input logic [6:0] c,
                             input logic [1:0] op, input logic [3:0] fn);
    mk = {pc, rd1, rd2, imm, rs1, rs2, rd, c, op, fn};
  endfunction

  function automatic ex_t nop_e(input logic [31:0] pc);
    nop_e = mk(pc, 0, 0, 0, 0, 0, 0, 7'b1000100, 2'b11, 4'h0);
  endfunction

  always @(posedge clk) begin
    #1;
    if (idex_q.size() > 0) begin
      mon_e  = idex_q.pop_front();
      mon_en = ex_nm_q.pop_front();
      checks++;
      if (act_ex !== mon_e) begin
        failures++;
        $display("FAIL %s idex act=%h exp=%h", mon_en, act_ex, mon_e);
      end
    end
  end

  always @(negedge clk) begin
    if (hz_q.size() > 0) begin
      mon_h  = hz_q.pop_front();
      mon_hn = hz_nm_q.pop_front();
      checks++;
      if (act_hz !== mon_h) begin
        failures++;
        $display("FAIL %s hz {pcw,wif,fl} act=%b exp=%b", mon_hn, act_hz, mon_h);
      end
    end
  end

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Drive one ID cycle (called at posedge+2), queue its expectations, advance.
  task automatic step(input string nm, input logic [31:0] ins, pc, input logic pcsrc,
                      input logic we, input logic [4:0] wrd, input logic [31:0] wd,
                      input ex_t e, input hz_t h);
    Instruc_IFID = ins; PC_IFID = pc; PCSrc_EX = pcsrc;
    RegWrite_WB = we; Rd_WB = wrd; WriteData_WB = wd;
    idex_q.push_back(e); ex_nm_q.push_back(nm);
    hz_q.push_back(h);   hz_nm_q.push_back(nm);
    @(posedge clk); #2;
  endtask

  localparam hz_t RUN = 3'b110;

  initial begin
    repeat (2) @(posedge clk);
    #2;
    chk("reset_idex", 192'(act_ex), 192'(BUB));
    chk("reset_hz", 192'(act_hz), 192'(3'b110));
    rst = 1'b0;

    step("wb_x5", 32'h13, 0, 0, 1, 5, 32'h55, nop_e(0), RUN);
    rst = 1'b1; #1;
    chk("midrun_reset_idex", 192'(act_ex), 192'(BUB));
    chk("midrun_reset_hz", 192'(act_hz), 192'(3'b110));
    @(posedge clk); #2;
    rst = 1'b0;

    step("wb_x1", 32'h13, 0, 0, 1, 1, 7, nop_e(0), RUN);
    step("wb_x2", 32'h13, 0, 0, 1, 2, 9, nop_e(0), RUN);
    step("add_x3", 32'h002081B3, 32'h40, 0, 0, 0, 0,
         mk(32'h40, 7, 9, 0, 1, 2, 3, 7'b1000000, 2'b10, 4'h0), RUN);
    step("lw_x5", 32'h0000A283, 32'h44, 0, 0, 0, 0,
         mk(32'h44, 7, 0, 0, 1, 0, 5, 7'b1101100, 2'b00, 4'h2), RUN);
    step("loaduse_stall", 32'h00228333, 32'h48, 0, 0, 0, 0, BUB, 3'b000);
    step("add_after_stall", 32'h00228333, 32'h48, 0, 0, 0, 0,
         mk(32'h48, 0, 9, 0, 5, 2, 6, 7'b1000000, 2'b10, 4'h0), RUN);
    step("lw_x0", 32'h0000A003, 32'h4C, 0, 0, 0, 0,
         mk(32'h4C, 7, 0, 0, 1, 0, 0, 7'b1101100, 2'b00, 4'h2), RUN);
    step("no_stall_rd0", 32'h00000333, 32'h50, 0, 0, 0, 0,
         mk(32'h50, 0, 0, 0, 0, 0, 6, 7'b1000000, 2'b10, 4'h0), RUN);
    step("lw_x5_b", 32'h0000A283, 32'h54, 0, 0, 0, 0,
         mk(32'h54, 7, 0, 0, 1, 0, 5, 7'b1101100, 2'b00, 4'h2), RUN);
    step("lui_no_stall", 32'h00028337, 32'h58, 0, 0, 0, 0,
         mk(32'h58, 0, 0, 32'h00028000, 0, 0, 6, 7'b1000100, 2'b00, 4'h0), RUN);
    step("bypass_addi", 32'hFFF08213, 32'h5C, 0, 1, 1, 32'hDEADBEEF,
         mk(32'h5C, 32'hDEADBEEF, 0, 32'hFFFFFFFF, 1, 31, 4, 7'b1000100, 2'b11, 4'h8), RUN);
    step("lw_x5_c", 32'h0000A283, 32'h60, 0, 0, 0, 0,
         mk(32'h60, 32'hDEADBEEF, 0, 0, 1, 0, 5, 7'b1101100, 2'b00, 4'h2), RUN);
    step("flush_prio", 32'h00228333, 32'h64, 1, 0, 0, 0, BUB, 3'b111);
    step("beq_m8", 32'hFE208CE3, 32'h68, 0, 0, 0, 0,
         mk(32'h68, 32'hDEADBEEF, 9, 32'hFFFFFFF8, 1, 2, 25, 7'b0000010, 2'b01, 4'h8), RUN);
    step("jal_2048", 32'h001000EF, 32'h6C, 0, 0, 0, 0,
         mk(32'h6C, 0, 32'hDEADBEEF, 32'h800, 0, 1, 1, 7'b1000001, 2'b00, 4'h0), RUN);
    step("sw_12", 32'h0020A623, 32'h70, 0, 0, 0, 0,
         mk(32'h70, 32'hDEADBEEF, 9, 32'hC, 1, 2, 12, 7'b0010100, 2'b00, 4'h2), RUN);
    step("lw_x5_d", 32'h0000A283, 32'h74, 0, 0, 0, 0,
         mk(32'h74, 32'hDEADBEEF, 0, 0, 1, 0, 5, 7'b1101100, 2'b00, 4'h2), RUN);

    // Reset arrives in the middle of a stall cycle.
    Instruc_IFID = 32'h00228333; PC_IFID = 32'h78;
    idex_q.push_back(BUB); ex_nm_q.push_back("stall_then_reset");
    hz_q.push_back(3'b000); hz_nm_q.push_back("stall_then_reset");
    @(negedge clk); #2;
    rst = 1'b1; #1;
    chk("reset_in_stall_idex", 192'(act_ex), 192'(BUB));
    chk("reset_in_stall_hz", 192'(act_hz), 192'(3'b110));
    @(posedge clk); #2;
    rst = 1'b0;

    step("nop_after_rst", 32'h13, 32'h80, 0, 0, 0, 0, nop_e(32'h80), RUN);
    step("x1_cleared", 32'hFFF08213, 32'h84, 0, 0, 0, 0,
         mk(32'h84, 0, 0, 32'hFFFFFFFF, 1, 31, 4, 7'b1000100, 2'b11, 4'h8), RUN);

    @(posedge clk); #3;
    chk("scoreboard_drained", 192'(idex_q.size() + hz_q.size()), 192'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog act=timeout exp=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/id_stage_hazard.md
Name: id_stage_hazard

Overview:
Instruction-decode stage that sits directly downstream of the IF stage and its IF/ID register. It consumes the fetched instruction and PC, and contains the following:
- 32x32 register file with WB write port.
- Immediate generator.
- Main control decoder.
- Load-use hazard detector, which drives the IF-stage PCWrite/Write_IFID stall controls.
- ID/EX pipeline register, with bubble insertion for stalls and EX branch flushes.

Parameters:
XLEN, 32, datapath width
NREG, 32, architectural registers (x0 hardwired to zero)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
Instruc_IFID  in  32  instruction from IF/ID register
PC_IFID  in  32  PC of that instruction
PCSrc_EX  in  1  branch/jump taken, resolved in EX this cycle
RegWrite_WB  in  1  WB write enable
Rd_WB  in  5  WB destination register
WriteData_WB  in  32  WB write data
PCWrite  out  1  PC enable to IF stage (0 = hold PC)
Write_IFID  out  1  IF/ID enable (0 = hold IF/ID)
Flush_IFID  out  1  top level forces IF/ID to NOP on next edge
IDEX_PC, IDEX_RD1, IDEX_RD2, IDEX_Imm  out  32 each  registered PC, operands, immediate
IDEX_Rs1, IDEX_Rs2, IDEX_Rd  out  5 each  registered register indices, for forwarding
IDEX_RegWrite, IDEX_MemRead, IDEX_MemWrite, IDEX_MemtoReg, IDEX_ALUSrc, IDEX_Branch, IDEX_Jump  out  1 each  registered controls
IDEX_ALUOp  out  2  00 add, 01 branch compare, 10 R-type funct, 11 I-type funct
IDEX_Funct  out  4  {instr[30], instr[14:12]}

Behaviour:
- Reset (async, rst=1):
  - All ID/EX outputs are 0, so the ID/EX register holds a NOP.
  - All register-file entries are cleared.
  - PCWrite=1, Write_IFID=1, Flush_IFID=0.
- Decode is combinational from Instruc_IFID. Decoded result enters ID/EX at the next edge, so latency is one cycle.
- Supported opcodes: R, I-ALU, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC. Any other opcode decodes as a NOP (all controls 0).
- Immediates are sign-extended to 32 bits:
  - I: [31:20]
  - S: {[31:25],[11:7]}
  - B: {[31],[7],[30:25],[11:8],0}
  - U: {[31:12],12'b0}
  - J: {[31],[19:12],[20],[30:21],0}
- LUI: Rs1 is forced to 0 so RD1=0. Decodes as ALUOp=00, ALUSrc=1.
- Register file:
  - Two async read ports, one sync write port.
  - Writes to x0 are ignored.
  - Write-through bypass: if RegWrite_WB and Rd_WB!=0 and Rd_WB equals a read index, that port returns WriteData_WB in the same cycle.
- Operand use:
  - rs1 is used by all types except LUI, AUIPC, JAL.
  - rs2 is used by R, STORE, BRANCH only.
- Load-use hazard: stall = IDEX_MemRead & IDEX_Rd!=0 & ((use_rs1 & IDEX_Rd==rs1) | (use_rs2 & IDEX_Rd==rs2)).
- On stall:
  - PCWrite=0, Write_IFID=0.
  - ID/EX loads a bubble: all controls 0, Rd=0, data fields don't-care but 0.
  - Stall lasts exactly one cycle, because next cycle IDEX_MemRead=0.
- Flush:
  - Flush_IFID = PCSrc_EX (combinational).
  - When PCSrc_EX=1, ID/EX loads a bubble.
  - PCSrc_EX has priority over stall: PCWrite=1 and Write_IFID=1 so the IF stage loads the target, and the wrong-path instruction is killed via Flush_IFID.
- Simultaneous WB write and stall: the register-file write still occurs, and the bypass still applies.
- Reset asserted mid-stall: outputs return to reset values immediately (asynchronous).

Decomposition:
- Shared package (riscv_pkg) holds:
  - Opcode constants (OP_R=0110011, OP_I=0010011, OP_LOAD=0000011, OP_STORE=0100011, OP_BRANCH=1100011, OP_JAL=1101111, OP_JALR=1100111, OP_LUI=0110111, OP_AUIPC=0010111).
  - ALUOp encodings.
  - NOP constant 32'h00000013.
- One natural sub-module: reg_file (2R1W with bypass and x0 handling).
- Decoder, immediate generator and hazard logic stay inline.

Test Plan:
1. Reset: assert rst mid-run -> all IDEX_* are 0, PCWrite=1, Write_IFID=1. After release, the x5 read returns 0.
2. Decode: with x1=7, x2=9 written via WB, Instruc_IFID=0x002081B3 (add x3,x1,x2), PC_IFID=0x40 -> next edge IDEX_RD1=7, IDEX_RD2=9, IDEX_Rd=3, IDEX_RegWrite=1, IDEX_ALUOp=10, IDEX_PC=0x40.
3. Load-use: lw x5,0(x1) followed by add x6,x5,x2 -> one cycle of PCWrite=0 and Write_IFID=0, with a bubble in ID/EX (IDEX_RegWrite=0, IDEX_Rd=0). The add enters ID/EX on the following edge. No stall when the consumer is lui x6 or when the load writes x0.
4. Bypass: RegWrite_WB=1, Rd_WB=1, WriteData_WB=0xDEADBEEF in the same cycle as decoding addi x4,x1,-1 -> IDEX_RD1=0xDEADBEEF, IDEX_Imm=0xFFFFFFFF.
5. Flush priority: PCSrc_EX=1 while a load-use stall condition exists -> PCWrite=1, Write_IFID=1, Flush_IFID=1, and ID/EX holds a bubble.
6. Immediates: beq with B-imm -8 -> IDEX_Imm=0xFFFFFFF8. jal with imm +2048 -> IDEX_Imm=0x00000800, IDEX_Jump=1. sw -> S-imm is correct and IDEX_MemWrite=1.
